e_mdu: RTL



---
 rtl/e_mdu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle mult/multu/div/divu,
// owns the architectural HI/LO registers and serves mfhi/mflo/mthi/mtlo.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  E_MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  output logic        E_MDU_Start,
  output logic        E_MDU_Busy,
  output logic [31:0] E_MDU_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_hi, w_hi_nxt;
  logic [31:0]      r_lo, w_lo_nxt;
  logic [31:0]      r_pend_hi, w_pend_hi_nxt;
  logic [31:0]      r_pend_lo, w_pend_lo_nxt;

  logic             w_is_mdu;
  logic             w_is_mult;
  logic             w_is_div;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_div_zero;
  logic [63:0]      w_prod_s;
  logic [63:0]      w_prod_u;
  logic [31:0]      w_dvd;
  logic [31:0]      w_dvs;
  logic [31:0]      w_dvs_safe;
  logic [31:0]      w_q_mag;
  logic [31:0]      w_r_mag;
  logic [31:0]      w_quot;
  logic [31:0]      w_rem;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;

  // Opcode decode and start handshake to the hazard unit
  assign w_is_mdu    = (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU);
  assign w_is_mult   = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);
  assign E_MDU_Start = w_is_mdu && (r_state == S_IDLE) && !Req;
  assign E_MDU_Busy  = (r_state == S_BUSY);
  assign HI          = r_hi;
  assign LO          = r_lo;

  // Products: sign- or zero-extend to 64 bits, low 64 bits are exact
  assign w_prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
  assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};

  // Signed divide via magnitudes; quotient truncates, remainder follows dividend
  assign w_is_div   = (E_MDUOp == OP_DIV);
  assign w_a_neg    = w_is_div && E_A[31];
  assign w_b_neg    = w_is_div && E_B[31];
  assign w_div_zero = (E_B == 32'd0);
  assign w_dvd      = w_a_neg ? (~E_A + 32'd1) : E_A;
  assign w_dvs      = w_b_neg ? (~E_B + 32'd1) : E_B;
  assign w_dvs_safe = w_div_zero ? 32'd1 : w_dvs;
  assign w_q_mag    = w_dvd / w_dvs_safe;
  assign w_r_mag    = w_dvd % w_dvs_safe;
  assign w_quot     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  // Result selection; divide by zero keeps the current HI/LO
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (E_MDUOp)
      OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      OP_DIV, OP_DIVU: begin
        if (!w_div_zero) begin
          w_res_hi = w_rem;
          w_res_lo = w_quot;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    E_MDU_out = 32'd0;
    case (E_MDUOp)
      OP_MFHI: E_MDU_out = r_hi;
      OP_MFLO: E_MDU_out = r_lo;
      default: ;
    endcase
  end

  // Next-state: start, countdown and commit, plus idle mthi/mtlo
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    case (r_state)
      S_IDLE: begin
        if (E_MDU_Start) begin
          w_state_nxt   = S_BUSY;
          w_cnt_nxt     = w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          w_pend_hi_nxt = w_res_hi;
          w_pend_lo_nxt = w_res_lo;
        end else if (!Req) begin
          if (E_MDUOp == OP_MTHI) w_hi_nxt = E_A;
          if (E_MDUOp == OP_MTLO) w_lo_nxt = E_A;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_hi_nxt    = r_pend_hi;
          w_lo_nxt    = r_pend_lo;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
    end
  end

endmodule
